// File: rtl/wl_afifo_rptr_empty_if.sv
// Read-side port bundle of the wl_afifo read pointer / empty controller.
// The master drives the read request, the clear and the raw write pointer.
// The slave (the controller) returns the pointers, the address and the flags.
interface wl_afifo_rptr_empty_if #(
  parameter int L = 3
);
  logic         rinc;
  logic         rclr;
  logic [L:0]   wq_gray_wptr;
  logic [L-1:0] raddr;
  logic [L:0]   bin_rptr;
  logic [L:0]   gray_rptr;
  logic [L:0]   r2_gray_wptr;
  logic         rempty;
  logic [L:0]   rcount;
  logic         runderflow;

  modport master (
    output rinc, rclr, wq_gray_wptr,
    input  raddr, bin_rptr, gray_rptr, r2_gray_wptr, rempty, rcount, runderflow
  );

  modport slave (
    input  rinc, rclr, wq_gray_wptr,
    output raddr, bin_rptr, gray_rptr, r2_gray_wptr, rempty, rcount, runderflow
  );
endinterface

// File: rtl/wl_afifo_rptr_empty.sv
// Read-side pointer and empty-flag controller for the wl_afifo async FIFO.
// Runs entirely in the read clock domain. The gray write pointer comes in
// through a two-flop synchronizer; the binary/gray read pointers, the
// registered empty flag, the fill count and a sticky underflow flag are
// kept here. Empty is computed from the next read pointer so it asserts on
// the same edge that pops the last entry.
module wl_afifo_rptr_empty #(
  parameter int L = 3
) (
  input  logic                 rclk,
  input  logic                 rrst,
  wl_afifo_rptr_empty_if.slave rif
);

  logic [L:0] bin_rptr_q, bin_rptr_d;
  logic [L:0] gray_rptr_q, gray_rptr_d;
  logic [L:0] r1_gray_wptr_q, r1_gray_wptr_d;
  logic [L:0] r2_gray_wptr_q, r2_gray_wptr_d;
  logic       rempty_q, rempty_d;
  logic [L:0] rcount_q, rcount_d;
  logic       runderflow_q, runderflow_d;

  logic       ren;
  logic [L:0] bin_next;
  logic [L:0] gray_next;
  logic [L:0] r2_bin_wptr;

  // Synchronizer next-state: a plain shift, untouched by rclr.
  always_comb begin
    r1_gray_wptr_d = rif.wq_gray_wptr;
    r2_gray_wptr_d = r1_gray_wptr_q;
  end

  // Gray-to-binary of the synchronized write pointer (MSB passes through).
  always_comb begin
    r2_bin_wptr = r2_gray_wptr_q;
    for (int i = L - 1; i >= 0; i--) begin
      r2_bin_wptr[i] = r2_gray_wptr_q[i] ^ r2_bin_wptr[i+1];
    end
  end

  // Read accept, next pointers, empty/count/underflow; clear wins over a read.
  always_comb begin
    ren          = rif.rinc & ~rempty_q;
    bin_next     = bin_rptr_q + {{L{1'b0}}, ren};
    gray_next    = bin_next ^ (bin_next >> 1);
    bin_rptr_d   = bin_next;
    gray_rptr_d  = gray_next;
    rempty_d     = (gray_next == r2_gray_wptr_q);
    rcount_d     = r2_bin_wptr - bin_next;
    runderflow_d = runderflow_q | (rif.rinc & rempty_q);
    if (rif.rclr) begin
      bin_rptr_d   = '0;
      gray_rptr_d  = '0;
      rempty_d     = 1'b1;
      rcount_d     = '0;
      runderflow_d = 1'b0;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      bin_rptr_q     <= '0;
      gray_rptr_q    <= '0;
      r1_gray_wptr_q <= '0;
      r2_gray_wptr_q <= '0;
      rempty_q       <= 1'b1;
      rcount_q       <= '0;
      runderflow_q   <= 1'b0;
    end else begin
      bin_rptr_q     <= bin_rptr_d;
      gray_rptr_q    <= gray_rptr_d;
      r1_gray_wptr_q <= r1_gray_wptr_d;
      r2_gray_wptr_q <= r2_gray_wptr_d;
      rempty_q       <= rempty_d;
      rcount_q       <= rcount_d;
      runderflow_q   <= runderflow_d;
    end
  end

  assign rif.raddr        = bin_rptr_q[L-1:0];
  assign rif.bin_rptr     = bin_rptr_q;
  assign rif.gray_rptr    = gray_rptr_q;
  assign rif.r2_gray_wptr = r2_gray_wptr_q;
  assign rif.rempty       = rempty_q;
  assign rif.rcount       = rcount_q;
  assign rif.runderflow   = runderflow_q;

endmodule

// File: tb/tb_wl_afifo_rptr_empty.sv
// Directed bench for wl_afifo_rptr_empty with L=3 (depth 8, 4-bit pointers).
module tb_wl_afifo_rptr_empty;
  localparam int L = 3;

  logic rclk;
  logic rrst;
  int   n_tests;
  int   n_fail;

  wl_afifo_rptr_empty_if #(.L(L)) rif ();

  wl_afifo_rptr_empty #(.L(L)) dut (
    .rclk (rclk),
    .rrst (rrst),
    .rif  (rif.slave)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  function automatic logic [L:0] gray(input int b);
    logic [L:0] v;
    v = b[L:0];
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // advance one rclk edge and land 1ns after it
  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  initial begin
    logic [L:0] prev_gray;
    int bexp;
    n_tests = 0;
    n_fail  = 0;
    rrst = 1'b1;
    rif.rinc = 1'b0;
    rif.rclr = 1'b0;
    rif.wq_gray_wptr = '0;
    step();
    step();
    // reset values
    chk("rst_bin", rif.bin_rptr, 0);
    chk("rst_gray", rif.gray_rptr, 0);
    chk("rst_raddr", rif.raddr, 0);
    chk("rst_r2", rif.r2_gray_wptr, 0);
    chk("rst_empty", rif.rempty, 1);
    chk("rst_count", rif.rcount, 0);
    chk("rst_uflow", rif.runderflow, 0);
    rrst = 1'b0;

    // reads while empty: pointer holds, underflow sticks
    rif.rinc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("uf_bin", rif.bin_rptr, 0);
      chk("uf_flag", rif.runderflow, 1);
    end
    rif.rinc = 1'b0;
    step();
    chk("uf_sticky", rif.runderflow, 1);
    rif.rclr = 1'b1;
    step();
    chk("uf_clr", rif.runderflow, 0);
    rif.rclr = 1'b0;

    // latency of one write
    rif.wq_gray_wptr = gray(1);
    step();
    chk("lat_r2_e1", rif.r2_gray_wptr, 0);
    chk("lat_empty_e1", rif.rempty, 1);
    step();
    chk("lat_r2_e2", rif.r2_gray_wptr, 1);
    chk("lat_empty_e2", rif.rempty, 1);
    step();
    chk("lat_empty_e3", rif.rempty, 0);
    chk("lat_count_e3", rif.rcount, 1);
    rif.rinc = 1'b1;
    step();
    rif.rinc = 1'b0;
    chk("lat_rd_bin", rif.bin_rptr, 1);
    chk("lat_rd_empty", rif.rempty, 1);
    chk("lat_rd_count", rif.rcount, 0);

    // clear read side with write side also cleared
    rif.wq_gray_wptr = '0;
    rif.rclr = 1'b1;
    step();
    rif.rclr = 1'b0;
    step();
    step();
    step();
    chk("clr_bin", rif.bin_rptr, 0);
    chk("clr_empty", rif.rempty, 1);

    // full count, drain and wrap: two rounds of 8 writes / 8 reads
    prev_gray = rif.gray_rptr;
    for (int r = 0; r < 2; r++) begin
      rif.wq_gray_wptr = gray(((r + 1) * 8) % 16);
      step();
      step();
      step();
      chk("full_count", rif.rcount, 8);
      chk("full_empty", rif.rempty, 0);
      rif.rinc = 1'b1;
      for (int k = 0; k < 8; k++) begin
        step();
        bexp = (r * 8 + k + 1) % 16;
        chk("drn_bin", rif.bin_rptr, bexp);
        chk("drn_gray", rif.gray_rptr, gray(bexp));
        chk("drn_1bit", $countones(prev_gray ^ rif.gray_rptr), 1);
        chk("drn_raddr", rif.raddr, bexp % 8);
        chk("drn_count", rif.rcount, 7 - k);
        chk("drn_empty", rif.rempty, (k == 7) ? 1 : 0);
        prev_gray = rif.gray_rptr;
      end
      rif.rinc = 1'b0;
    end
    chk("wrap_bin", rif.bin_rptr, 0);

    // reach bin=5, underflow, then rinc+rclr together
    rif.wq_gray_wptr = gray(5);
    step();
    step();
    step();
    rif.rinc = 1'b1;
    for (int k = 0; k < 5; k++) step();
    chk("act_bin5", rif.bin_rptr, 5);
    chk("act_empty5", rif.rempty, 1);
    step();
    chk("act_uf_bin", rif.bin_rptr, 5);
    chk("act_uf", rif.runderflow, 1);
    rif.rclr = 1'b1;
    rif.wq_gray_wptr = '0;
    step();
    rif.rinc = 1'b0;
    chk("rclr_bin", rif.bin_rptr, 0);
    chk("rclr_gray", rif.gray_rptr, 0);
    chk("rclr_empty", rif.rempty, 1);
    chk("rclr_count", rif.rcount, 0);
    chk("rclr_uf", rif.runderflow, 0);
    step();
    step();

    // synchronizer keeps tracking while rclr is held
    rif.wq_gray_wptr = gray(3);
    step();
    chk("sync_e1", rif.r2_gray_wptr, 0);
    step();
    chk("sync_e2", rif.r2_gray_wptr, gray(3));
    chk("sync_empty", rif.rempty, 1);
    chk("sync_count", rif.rcount, 0);
    rif.rclr = 1'b0;
    step();
    chk("sync_rel_empty", rif.rempty, 0);
    chk("sync_rel_count", rif.rcount, 3);

    // two reads, then an asynchronous reset in mid-cycle
    rif.rinc = 1'b1;
    step();
    step();
    rif.rinc = 1'b0;
    chk("pre_rst_bin", rif.bin_rptr, 2);
    chk("pre_rst_count", rif.rcount, 1);
    #3;
    rrst = 1'b1;
    #1;
    chk("arst_bin", rif.bin_rptr, 0);
    chk("arst_gray", rif.gray_rptr, 0);
    chk("arst_raddr", rif.raddr, 0);
    chk("arst_r2", rif.r2_gray_wptr, 0);
    chk("arst_empty", rif.rempty, 1);
    chk("arst_count", rif.rcount, 0);
    step();
    rrst = 1'b0;
    rif.wq_gray_wptr = '0;
    step();
    chk("post_rst_empty", rif.rempty, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
